dtm_dmi_master: RTL and testbench
=================================

DTM_DMI_MASTER -- requirements
Module: dtm_dmi_master

Interface
REQ-001 SHALL have parameters: DBUS_OP_WIDTH, default 2, DMI op field width; DBUS_ADDR_WIDTH, default 7, DM register address width; DBUS_DATA_WIDTH, default 32, data width; TIMEOUT, default 255, response-wait limit in cycles.
REQ-002 SHALL have ports: sys_clk in 1, clock; sys_rstn in 1, reset, asynchronous, active-low.
REQ-003 SHALL have ports: dmi_req_valid in 1, one-cycle request pulse from the JTAG DMI shift register (already in sys_clk domain); dmi_req_op in 2, 0 nop, 1 read, 2 write, 3 reserved; dmi_req_addr in ADDR; dmi_req_data in DATA.
REQ-004 SHALL have ports: dmireset in 1, pulse, clears sticky status; dmihardreset in 1, pulse, aborts any transaction.
REQ-005 SHALL have ports: dmi_busy out 1, transaction in flight; dmi_done out 1, one-cycle completion pulse; dmi_rdata out DATA, captured read data; dmi_stat out 2, 0 ok, 2 failed, 3 busy (sticky).
REQ-006 SHALL have ports: dtm_req_valid out 1; dtm_req_ready in 1; dtm_req_bits out OP+ADDR+DATA (41), packed [1:0] op, [8:2] addr, [40:9] data.
REQ-007 SHALL have ports: dm_resp_valid in 1; dm_resp_ready out 1; dm_resp_bits in OP+DATA (34), [33:32] op echo, [31:0] read data.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT_RESP, DONE.
REQ-009 IDLE: on dmi_req_valid with op 1 or 2 and dmi_stat==0, SHALL latch op/addr/data into dtm_req_bits and go to REQ; op 0 or 3 SHALL produce a dmi_done pulse next cycle with no DM access.
REQ-010 REQ: dtm_req_valid SHALL equal (state==REQ && dtm_req_ready), so the DM sees exactly one valid cycle per access; while ready is low, SHALL stay in REQ with valid low.
REQ-011 On the REQ handshake cycle, a write SHALL go to DONE; a read SHALL go to WAIT_RESP.
REQ-012 WAIT_RESP: dm_resp_ready SHALL be 1; on dm_resp_valid, SHALL capture dm_resp_bits[31:0] into dmi_rdata and go to DONE; dm_resp_ready SHALL be 0 in all other states.
REQ-013 An 8-bit wait counter SHALL clear on WAIT_RESP entry and increment each WAIT_RESP cycle; when it reaches TIMEOUT with no dm_resp_valid, SHALL set dmi_stat=2 and go to DONE with dmi_rdata unchanged.
REQ-014 DONE: dmi_done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-015 dmi_busy SHALL be 1 in REQ, WAIT_RESP and DONE, and 0 in IDLE.
REQ-016 dmi_req_valid while dmi_busy==1 SHALL be dropped and SHALL set dmi_stat=3 unless dmi_stat is already nonzero; the in-flight transaction SHALL continue unaffected.
REQ-017 dmi_stat SHALL be sticky; while it is nonzero, new requests SHALL be ignored without any DM access and SHALL produce no dmi_done.
REQ-018 dmireset SHALL clear dmi_stat to 0 next cycle without changing FSM state; if coincident with an error-setting event, dmireset SHALL win.
REQ-019 dmihardreset SHALL force IDLE, dtm_req_valid=0, dm_resp_ready=0, dmi_stat=0 and wait counter=0 next cycle, suppressing dmi_done; a dm_resp_valid arriving later in IDLE SHALL be ignored.
REQ-020 The latency from dmi_req_valid to dtm_req_valid SHALL be 1 cycle when dtm_req_ready is high; a write SHALL complete (dmi_done) 2 cycles after the handshake cycle.

Reset
REQ-021 On sys_rstn low, SHALL set state=IDLE, dtm_req_valid=0, dtm_req_bits=0, dm_resp_ready=0, dmi_busy=0, dmi_done=0, dmi_rdata=0, dmi_stat=0 and wait counter=0.
REQ-022 Reset asserted mid-transaction SHALL abandon it, with no dmi_done after release.

Verification
REQ-023 Write addr 0x04, data 0xA5A5_0001, ready=1 -> dtm_req_bits={0xA5A50001,0x04,2'b10} valid 1 cycle at T+1; dmi_done at T+3; dmi_stat=0.
REQ-024 Read addr 0x3C, DM returns 0x1234_5678 two cycles after the handshake -> dmi_rdata=0x12345678, one dmi_done pulse, dm_resp_ready high only in WAIT_RESP.
REQ-025 dtm_req_ready held low 5 cycles, then high -> exactly one dtm_req_valid cycle, coincident with the first ready-high cycle.
REQ-026 Read with no response -> dmi_stat=2 after 255 WAIT_RESP cycles; the next request is ignored; dmireset -> stat=0; the following read succeeds.
REQ-027 Second dmi_req_valid during WAIT_RESP -> dmi_stat=3 and the first read still completes with its own data; dmihardreset during WAIT_RESP -> IDLE next cycle, no dmi_done.

Source files
------------

// File: rtl/dtm_dmi_master.sv
// DMI master: turns one-cycle DMI requests from the JTAG TAP side into a single
// request/response exchange with the Debug Module, with sticky error status,
// a response timeout and a hard abort.
module dtm_dmi_master #(
  parameter int DBUS_OP_WIDTH   = 2,
  parameter int DBUS_ADDR_WIDTH = 7,
  parameter int DBUS_DATA_WIDTH = 32,
  parameter int TIMEOUT         = 255
) (
  input  logic                                                   sys_clk,
  input  logic                                                   sys_rstn,
  input  logic                                                   dmi_req_valid,
  input  logic [DBUS_OP_WIDTH-1:0]                               dmi_req_op,
  input  logic [DBUS_ADDR_WIDTH-1:0]                             dmi_req_addr,
  input  logic [DBUS_DATA_WIDTH-1:0]                             dmi_req_data,
  input  logic                                                   dmireset,
  input  logic                                                   dmihardreset,
  output logic                                                   dmi_busy,
  output logic                                                   dmi_done,
  output logic [DBUS_DATA_WIDTH-1:0]                             dmi_rdata,
  output logic [1:0]                                             dmi_stat,
  output logic                                                   dtm_req_valid,
  input  logic                                                   dtm_req_ready,
  output logic [DBUS_OP_WIDTH+DBUS_ADDR_WIDTH+DBUS_DATA_WIDTH-1:0] dtm_req_bits,
  input  logic                                                   dm_resp_valid,
  output logic                                                   dm_resp_ready,
  input  logic [DBUS_OP_WIDTH+DBUS_DATA_WIDTH-1:0]               dm_resp_bits
);

  localparam int REQ_W = DBUS_OP_WIDTH + DBUS_ADDR_WIDTH + DBUS_DATA_WIDTH;

  localparam logic [DBUS_OP_WIDTH-1:0] OP_READ  = DBUS_OP_WIDTH'(1);
  localparam logic [DBUS_OP_WIDTH-1:0] OP_WRITE = DBUS_OP_WIDTH'(2);

  localparam logic [1:0] STAT_OK     = 2'd0;
  localparam logic [1:0] STAT_FAILED = 2'd2;
  localparam logic [1:0] STAT_BUSY   = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_e;

  state_e                     state_q;
  logic [REQ_W-1:0]           req_bits_q;
  logic [DBUS_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                 stat_q, stat_d;
  logic                       done_q;
  logic [7:0]                 wait_cnt_q;

  logic access_op, is_write, timeout, overlap;

  // The op echo in the response carries nothing this block needs.
  logic unused_resp_op;
  assign unused_resp_op = ^dm_resp_bits[DBUS_OP_WIDTH+DBUS_DATA_WIDTH-1:DBUS_DATA_WIDTH];

  assign access_op = (dmi_req_op == OP_READ) || (dmi_req_op == OP_WRITE);
  assign is_write  = (req_bits_q[DBUS_OP_WIDTH-1:0] == OP_WRITE);
  assign timeout   = (state_q == WAIT_RESP) && !dm_resp_valid &&
                     (wait_cnt_q == 8'(TIMEOUT - 1));
  assign overlap   = dmi_req_valid && dmi_busy && (stat_q == STAT_OK);

  // Valid is gated by ready so the DM sees exactly one valid cycle per access.
  assign dtm_req_valid = (state_q == REQ) && dtm_req_ready;
  assign dm_resp_ready = (state_q == WAIT_RESP);
  assign dmi_busy      = (state_q != IDLE);
  assign dmi_done      = done_q;
  assign dmi_rdata     = rdata_q;
  assign dmi_stat      = stat_q;
  assign dtm_req_bits  = req_bits_q;

  // Sticky status: timeout outranks a dropped-request flag, any reset outranks both.
  always_comb begin
    stat_d = stat_q;
    if (overlap)                   stat_d = STAT_BUSY;
    if (timeout)                   stat_d = STAT_FAILED;
    if (dmireset || dmihardreset)  stat_d = STAT_OK;
  end

  // Transaction FSM with its registered datapath and completion pulse.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q    <= IDLE;
      req_bits_q <= '0;
      rdata_q    <= '0;
      stat_q     <= STAT_OK;
      done_q     <= 1'b0;
      wait_cnt_q <= '0;
    end else if (dmihardreset) begin
      state_q    <= IDLE;
      stat_q     <= stat_d;
      done_q     <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      stat_q <= stat_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dmi_req_valid && (stat_q == STAT_OK)) begin
            if (access_op) begin
              req_bits_q <= {dmi_req_data, dmi_req_addr, dmi_req_op};
              state_q    <= REQ;
            end else begin
              done_q <= 1'b1;   // nop/reserved: acknowledge without a DM access
            end
          end
        end
        REQ: begin
          if (dtm_req_ready) begin
            wait_cnt_q <= '0;
            state_q    <= is_write ? DONE : WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          if (dm_resp_valid) begin
            rdata_q <= dm_resp_bits[DBUS_DATA_WIDTH-1:0];
            state_q <= DONE;
          end else if (timeout) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtm_dmi_master.sv
// Randomized + directed bench for dtm_dmi_master against a transaction-level model.
module tb_dtm_dmi_master;
  localparam int OW = 2, AW = 7, DW = 32, TO = 255;

  logic              sys_clk = 1'b0;
  logic              sys_rstn;
  logic              dmi_req_valid;
  logic [OW-1:0]     dmi_req_op;
  logic [AW-1:0]     dmi_req_addr;
  logic [DW-1:0]     dmi_req_data;
  logic              dmireset, dmihardreset;
  logic              dmi_busy, dmi_done;
  logic [DW-1:0]     dmi_rdata;
  logic [1:0]        dmi_stat;
  logic              dtm_req_valid, dtm_req_ready;
  logic [OW+AW+DW-1:0] dtm_req_bits;
  logic              dm_resp_valid, dm_resp_ready;
  logic [OW+DW-1:0]  dm_resp_bits;

  int n_chk = 0, n_err = 0;
  int nv, nw, nd, guard;
  bit silent;

  // Transaction-level model: one open access, its progress flags and the sticky status.
  bit              m_open, m_rd, m_acc, m_res, m_done;
  int              m_wait;
  logic [1:0]      m_stat;
  logic [DW-1:0]   m_rdata;
  logic [OW+AW+DW-1:0] m_bits;

  always #5 sys_clk = ~sys_clk;

  dtm_dmi_master #(.DBUS_OP_WIDTH(OW), .DBUS_ADDR_WIDTH(AW), .DBUS_DATA_WIDTH(DW),
                   .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn),
    .dmi_req_valid(dmi_req_valid), .dmi_req_op(dmi_req_op), .dmi_req_addr(dmi_req_addr),
    .dmi_req_data(dmi_req_data), .dmireset(dmireset), .dmihardreset(dmihardreset),
    .dmi_busy(dmi_busy), .dmi_done(dmi_done), .dmi_rdata(dmi_rdata), .dmi_stat(dmi_stat),
    .dtm_req_valid(dtm_req_valid), .dtm_req_ready(dtm_req_ready), .dtm_req_bits(dtm_req_bits),
    .dm_resp_valid(dm_resp_valid), .dm_resp_ready(dm_resp_ready), .dm_resp_bits(dm_resp_bits)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_open = 0; m_rd = 0; m_acc = 0; m_res = 0; m_done = 0; m_wait = 0;
    m_stat = 2'd0; m_rdata = '0; m_bits = '0;
  endtask

  task automatic model_chk();
    chk("busy",     dmi_busy,      m_open);
    chk("dtm_vld",  dtm_req_valid, m_open && !m_acc && dtm_req_ready);
    chk("resp_rdy", dm_resp_ready, m_open && m_acc && m_rd && !m_res);
    chk("done",     dmi_done,      m_done);
    chk("stat",     dmi_stat,      m_stat);
    chk("rdata",    dmi_rdata,     m_rdata);
    chk("req_bits", dtm_req_bits,  m_bits);
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [1:0] ns;
    bit nd_l;
    if (!sys_rstn) begin m_reset(); return; end
    if (dmihardreset) begin m_open = 0; m_stat = 2'd0; m_done = 0; return; end
    ns = m_stat; nd_l = 0;
    if (!m_open) begin
      if (dmi_req_valid && m_stat == 2'd0) begin
        if (dmi_req_op == 2'd1 || dmi_req_op == 2'd2) begin
          m_open = 1; m_rd = (dmi_req_op == 2'd1); m_acc = 0; m_res = 0;
          m_bits = {dmi_req_data, dmi_req_addr, dmi_req_op};
        end else nd_l = 1;
      end
    end else begin
      if (dmi_req_valid && m_stat == 2'd0) ns = 2'd3;
      if (!m_acc) begin
        if (dtm_req_ready) begin m_acc = 1; m_res = !m_rd; m_wait = 0; end
      end else if (!m_res) begin
        m_wait++;
        if (dm_resp_valid) begin m_rdata = dm_resp_bits[DW-1:0]; m_res = 1; end
        else if (m_wait == TO) begin ns = 2'd2; m_res = 1; end
      end else begin
        m_open = 0; nd_l = 1;
      end
    end
    if (dmireset) ns = 2'd0;
    m_stat = ns; m_done = nd_l;
  endtask

  // One clock: check at the falling edge, step the model, drop pulses after the rising edge.
  task automatic cyc();
    @(negedge sys_clk);
    if (!sys_rstn) m_reset();
    model_chk();
    model_edge();
    @(posedge sys_clk); #1;
    dmi_req_valid = 0; dmireset = 0; dmihardreset = 0;
  endtask

  task automatic req(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
    dmi_req_valid = 1; dmi_req_op = op; dmi_req_addr = a; dmi_req_data = d;
  endtask

  initial begin
    sys_rstn = 1; dmi_req_valid = 0; dmi_req_op = '0; dmi_req_addr = '0; dmi_req_data = '0;
    dmireset = 0; dmihardreset = 0; dtm_req_ready = 0; dm_resp_valid = 0; dm_resp_bits = '0;
    m_reset();
    #1 sys_rstn = 0;
    @(posedge sys_clk); #1;
    cyc(); cyc();
    chk("rst_bits", dtm_req_bits, 0);
    chk("rst_busy", dmi_busy, 0);
    sys_rstn = 1;
    cyc();

    // Write: valid one cycle after the request, done two cycles after the handshake.
    dtm_req_ready = 1;
    req(2, 7'h04, 32'hA5A50001); cyc();
    chk("wr_vld_t1", dtm_req_valid, 1);
    chk("wr_bits", dtm_req_bits, {32'hA5A50001, 7'h04, 2'b10});
    cyc();
    chk("wr_vld_t2", dtm_req_valid, 0);
    chk("wr_done_t2", dmi_done, 0);
    cyc();
    chk("wr_done_t3", dmi_done, 1);
    chk("wr_stat", dmi_stat, 0);
    cyc();

    // Read with response two cycles after the handshake.
    req(1, 7'h3C, 32'h0); cyc();
    chk("rd_rdy_req", dm_resp_ready, 0);
    cyc();
    chk("rd_rdy_w1", dm_resp_ready, 1);
    cyc();
    dm_resp_valid = 1; dm_resp_bits = {2'b01, 32'h12345678};
    cyc();
    dm_resp_valid = 0;
    chk("rd_rdy_done", dm_resp_ready, 0);
    cyc();
    chk("rd_done", dmi_done, 1);
    chk("rd_data", dmi_rdata, 32'h12345678);
    cyc();

    // Ready held low for five cycles.
    dtm_req_ready = 0;
    req(2, 7'h11, 32'h0000DEAD); cyc();
    nv = 0;
    repeat (5) begin nv += int'(dtm_req_valid); cyc(); end
    chk("rdylo_novld", nv, 0);
    dtm_req_ready = 1; #1;
    chk("rdyhi_vld", dtm_req_valid, 1);
    cyc();
    chk("rdyhi_once", dtm_req_valid, 0);
    cyc(); cyc();

    // Read timeout, sticky status, dmireset, then a good read.
    req(1, 7'h20, 32'h0); cyc(); cyc();
    nw = 0; guard = 0;
    while (dmi_stat != 2'd2 && guard < 400) begin nw += int'(dm_resp_ready); cyc(); guard++; end
    chk("to_stat", dmi_stat, 2);
    chk("to_cycles", nw, 255);
    cyc(); cyc();
    req(2, 7'h01, 32'h5); cyc();
    nd = 0; nv = 0;
    repeat (3) begin nd += int'(dmi_done); nv += int'(dmi_busy); cyc(); end
    chk("sticky_nodone", nd, 0);
    chk("sticky_nobusy", nv, 0);
    dmireset = 1; cyc();
    chk("dmireset_stat", dmi_stat, 0);
    req(1, 7'h05, 32'h0); cyc(); cyc();
    dm_resp_valid = 1; dm_resp_bits = {2'b01, 32'hCAFEF00D}; cyc();
    dm_resp_valid = 0; cyc();
    chk("post_to_done", dmi_done, 1);
    chk("post_to_data", dmi_rdata, 32'hCAFEF00D);
    cyc();

    // Overlapping request during WAIT_RESP.
    req(1, 7'h06, 32'h0); cyc(); cyc();
    req(2, 7'h07, 32'h1); cyc();
    chk("ovl_stat", dmi_stat, 3);
    dm_resp_valid = 1; dm_resp_bits = {2'b01, 32'h0BADBEEF}; cyc();
    dm_resp_valid = 0; cyc();
    chk("ovl_done", dmi_done, 1);
    chk("ovl_data", dmi_rdata, 32'h0BADBEEF);
    dmireset = 1; cyc();
    chk("ovl_clr", dmi_stat, 0);

    // Hard reset during WAIT_RESP; later response is ignored.
    req(1, 7'h08, 32'h0); cyc(); cyc();
    chk("hr_wait", dm_resp_ready, 1);
    dmihardreset = 1; cyc();
    chk("hr_busy", dmi_busy, 0);
    chk("hr_rdy", dm_resp_ready, 0);
    dm_resp_valid = 1; dm_resp_bits = {2'b01, 32'hFFFF0000};
    nd = 0;
    repeat (4) begin nd += int'(dmi_done); cyc(); end
    dm_resp_valid = 0;
    chk("hr_nodone", nd, 0);
    chk("hr_rdata", dmi_rdata, 32'h0BADBEEF);

    // Nop and reserved ops complete next cycle without an access.
    req(0, 7'h09, 32'h0); cyc();
    chk("nop_done", dmi_done, 1);
    chk("nop_busy", dmi_busy, 0);
    req(3, 7'h09, 32'h0); cyc();
    chk("rsv_done", dmi_done, 1);
    cyc();

    // Reset in the middle of a read.
    req(1, 7'h0A, 32'h0); cyc(); cyc();
    sys_rstn = 0; cyc();
    sys_rstn = 1;
    nd = 0;
    repeat (4) begin nd += int'(dmi_done); cyc(); end
    chk("rst_mid_nodone", nd, 0);
    chk("rst_mid_rdata", dmi_rdata, 0);

    // Random traffic, checked every cycle by the model.
    silent = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) silent = !silent;
      dmi_req_valid = ($urandom_range(0, 5) == 0);
      dmi_req_op    = 2'($urandom);
      dmi_req_addr  = 7'($urandom);
      dmi_req_data  = $urandom;
      dtm_req_ready = ($urandom_range(0, 9) < 7);
      dm_resp_valid = !silent && ($urandom_range(0, 9) < 3);
      dm_resp_bits  = {2'($urandom), $urandom};
      dmireset      = ($urandom_range(0, 39) == 0);
      dmihardreset  = ($urandom_range(0, 149) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
